// File: rtl/gpio_cond_pkg.sv
// rtl/gpio_cond_pkg.sv - shared constants and sizing helpers for the GPIO input conditioner
package gpio_cond_pkg;

  localparam int unsigned BOARD_W_IN = 21;
  localparam logic [BOARD_W_IN-1:0] BOARD_ACTIVE_LOW_MASK = 21'h000007;

  // Clock cycles per 1 ms debounce tick.
  function automatic int unsigned TICK_CYCLES(input int unsigned clk_mhz);
    return clk_mhz * 1000;
  endfunction

  function automatic int unsigned DB_CNT_W(input int unsigned debounce_ms);
    return $clog2(debounce_ms + 1);
  endfunction

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// rtl/gpio_in_conditioner_if.sv - board-pin side and SoC side signals of the GPIO input conditioner
interface gpio_in_conditioner_if #(
  parameter int W_IN = gpio_cond_pkg::BOARD_W_IN
);
  logic [W_IN-1:0] raw_in;
  logic [W_IN-1:0] edge_clr;
  logic [W_IN-1:0] level_out;
  logic [W_IN-1:0] rise_pulse;
  logic [W_IN-1:0] fall_pulse;
  logic [W_IN-1:0] rise_sticky;
  logic            event_pending;

  modport master (
    output raw_in, edge_clr,
    input  level_out, rise_pulse, fall_pulse, rise_sticky, event_pending
  );

  modport slave (
    input  raw_in, edge_clr,
    output level_out, rise_pulse, fall_pulse, rise_sticky, event_pending
  );
endinterface

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - synchronizer, tick-based debounce counter and edge detect for one pin
// INIT is the pin's inactive raw level; the level output is normalized to active-high.
module gpio_debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          INIT        = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = DB_CNT_W(DEBOUNCE_MS);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    // Any return to the stable value drops all accumulated credit.
    if (sync_last == stable_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
        stable_d = sync_last;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    level_d = stable_q ^ INIT;
    rise_d  = level_d & ~level_q;
    fall_d  = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= {SYNC_STAGES{INIT}};
      stable_q <= INIT;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// rtl/gpio_in_conditioner.sv - conditions KEY/SW pins into debounced active-high levels and edge events
// Sticky rise flags and event_pending exist only when GPIO_COND_STICKY_EN is defined.
module gpio_in_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int unsigned     W_IN            = BOARD_W_IN,
  parameter int unsigned     CLK_MHZ         = 50,
  parameter int unsigned     DEBOUNCE_MS     = 10,
  parameter int unsigned     SYNC_STAGES     = 2,
  parameter logic [W_IN-1:0] ACTIVE_LOW_MASK = W_IN'(BOARD_ACTIVE_LOW_MASK)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  gpio_in_conditioner_if.slave  gpio
);

  localparam int unsigned TICKS = TICK_CYCLES(CLK_MHZ);
  localparam int unsigned PW    = $clog2(TICKS);

  logic [PW-1:0]   presc_q, presc_d;
  logic            tick;
  logic [W_IN-1:0] level_w, rise_w, fall_w;

  // One prescaler shared by every bit keeps all debounce windows phase-aligned.
  always_comb begin
    tick    = (presc_q == PW'(TICKS - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end

  for (genvar i = 0; i < W_IN; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT        (ACTIVE_LOW_MASK[i])
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .raw     (gpio.raw_in[i]),
      .level   (level_w[i]),
      .rise    (rise_w[i]),
      .fall    (fall_w[i])
    );
  end

  assign gpio.level_out  = level_w;
  assign gpio.rise_pulse = rise_w;
  assign gpio.fall_pulse = fall_w;

`ifdef GPIO_COND_STICKY_EN
  logic [W_IN-1:0] sticky_q, sticky_d;
  logic            pend_q, pend_d;

  // A set in the same cycle as a clear wins so no rise is ever lost.
  always_comb begin
    sticky_d = rise_w | (sticky_q & ~gpio.edge_clr);
    pend_d   = |sticky_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      pend_q   <= pend_d;
    end
  end

  assign gpio.rise_sticky   = sticky_q;
  assign gpio.event_pending = pend_q;
`else
  logic unused_edge_clr;

  assign unused_edge_clr    = ^gpio.edge_clr;
  assign gpio.rise_sticky   = '0;
  assign gpio.event_pending = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb/tb_gpio_in_conditioner.sv - directed self-checking bench for gpio_in_conditioner
// Runs with a 1 ms tick of 1000 cycles and a 3-tick debounce.
module tb_gpio_in_conditioner;

  localparam int W = 21;
  localparam logic [W-1:0] ACT = 21'h1FFFF8;
`ifdef GPIO_COND_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gpio_in_conditioner_if #(.W_IN(W)) bus ();

  gpio_in_conditioner #(
    .W_IN            (W),
    .CLK_MHZ         (1),
    .DEBOUNCE_MS     (3),
    .SYNC_STAGES     (2),
    .ACTIVE_LOW_MASK (21'h000007)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .gpio    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rise_cnt [W] = '{default: 0};
  int fall_cnt [W] = '{default: 0};
  int both_cnt = 0;
  int ph;

  always @(negedge clk) begin
    for (int i = 0; i < W; i++) begin
      if (bus.rise_pulse[i] === 1'b1) rise_cnt[i] <= rise_cnt[i] + 1;
      if (bus.fall_pulse[i] === 1'b1) fall_cnt[i] <= fall_cnt[i] + 1;
    end
    if ((bus.rise_pulse & bus.fall_pulse) != '0) both_cnt <= both_cnt + 1;
  end

  // Expected prescaler phase, used to place a press just after a tick.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ph <= 0;
    else          ph <= (ph == 999) ? 0 : ph + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int r5;
    int f5;
    bit changed;

    bus.raw_in   = '1;
    bus.edge_clr = '0;
    reset_n      = 1'b0;
    repeat (5) step();
    chk("rst_level", bus.level_out, 0);
    chk("rst_rise", bus.rise_pulse, 0);
    chk("rst_fall", bus.fall_pulse, 0);
    chk("rst_sticky", bus.rise_sticky, 0);
    chk("rst_pending", bus.event_pending, 0);

    reset_n = 1'b1;
    step();
    chk("rel_rise_c1", bus.rise_pulse, 0);
    chk("rel_fall_c1", bus.fall_pulse, 0);
    step();
    chk("rel_rise_c2", bus.rise_pulse, 0);
    chk("rel_fall_c2", bus.fall_pulse, 0);
    n = 0;
    while (bus.level_out !== ACT && n < 3100) begin step(); n++; end
    chk("rel_level", bus.level_out, ACT);
    chk("rel_rise_burst", bus.rise_pulse, ACT);
    step();
    chk("rel_rise_one_cycle", bus.rise_pulse, 0);
    chk("rel_sticky", bus.rise_sticky, STICKY ? ACT : '0);
    step();
    chk("rel_pending", bus.event_pending, STICKY);
    step();
    chk("rel_rise_cnt3", rise_cnt[3], 1);
    chk("rel_rise_cnt20", rise_cnt[20], 1);
    chk("rel_rise_cnt0", rise_cnt[0], 0);
    bus.edge_clr = '1; step(); bus.edge_clr = '0; step();
    chk("clr_all_1", bus.rise_sticky, 0);

    bus.raw_in[0] = 1'b0;
    n = 0;
    while (bus.level_out[0] !== 1'b1 && n < 3100) begin step(); n++; end
    chk("press_latency_ok", (n >= 2000 && n <= 3003), 1);
    chk("press_rise", bus.rise_pulse[0], 1);
    chk("press_fall", bus.fall_pulse[0], 0);
    step();
    chk("press_rise_end", bus.rise_pulse[0], 0);
    chk("press_sticky", bus.rise_sticky[0], STICKY);
    chk("press_rise_cnt", rise_cnt[0], 1);

    bus.raw_in[5] = 1'b0;
    n = 0;
    while (bus.level_out[5] !== 1'b0 && n < 3100) begin step(); n++; end
    chk("b5_low", bus.level_out[5], 0);
    step();
    r5 = rise_cnt[5];
    f5 = fall_cnt[5];
    changed = 1'b0;
    for (int k = 0; k < 13; k++) begin
      bus.raw_in[5] = (k % 2 == 0);
      repeat (1500) begin
        step();
        if (bus.level_out[5] !== 1'b0) changed = 1'b1;
      end
    end
    chk("bounce_level_steady", changed, 0);
    chk("bounce_rise_none", rise_cnt[5] - r5, 0);
    chk("bounce_fall_none", fall_cnt[5] - f5, 0);
    bus.raw_in[5] = 1'b1;
    n = 0;
    while (bus.level_out[5] !== 1'b1 && n < 3003) begin step(); n++; end
    chk("bounce_hold_level", bus.level_out[5], 1);

    bus.raw_in[0] = 1'b1;
    n = 0;
    while (bus.level_out[0] !== 1'b0 && n < 3100) begin step(); n++; end
    chk("release_level", bus.level_out[0], 0);
    chk("release_fall", bus.fall_pulse[0], 1);
    chk("release_rise", bus.rise_pulse[0], 0);
    step();
    chk("release_fall_end", bus.fall_pulse[0], 0);
    chk("release_sticky_kept", bus.rise_sticky[0], STICKY);
    bus.edge_clr = '1; step(); bus.edge_clr = '0; step();
    chk("clr_all_2", bus.rise_sticky, 0);

    bus.raw_in[0] = 1'b0;
    n = 0;
    while (bus.rise_pulse[0] !== 1'b1 && n < 3100) begin step(); n++; end
    chk("hs_rise", bus.rise_pulse[0], 1);
    bus.edge_clr[0] = 1'b1;
    step();
    chk("hs_set_wins", bus.rise_sticky[0], STICKY);
    step();
    chk("hs_cleared", bus.rise_sticky[0], 0);
    chk("hs_pending_lag", bus.event_pending, STICKY);
    bus.edge_clr[0] = 1'b0;
    step();
    chk("hs_pending_clear", bus.event_pending, 0);

    n = 0;
    while (ph != 998 && n < 1100) begin step(); n++; end
    chk("mid_phase_found", ph, 998);
    bus.raw_in[1] = 1'b0;
    repeat (2500) step();
    chk("mid_level1_pending", bus.level_out[1], 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_level", bus.level_out, 0);
    chk("mid_rst_rise", bus.rise_pulse, 0);
    chk("mid_rst_fall", bus.fall_pulse, 0);
    chk("mid_rst_sticky", bus.rise_sticky, 0);
    chk("mid_rst_pending", bus.event_pending, 0);
    step(); step();
    reset_n = 1'b1;
    n = 0;
    while (bus.level_out[1] !== 1'b1 && n < 3100) begin step(); n++; end
    chk("fresh_latency_ok", (n >= 2000 && n <= 3003), 1);
    chk("fresh_level", bus.level_out, 21'h1FFFFB);
    step();
    chk("no_dual_pulse", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
